// File: rtl/perf_pkg.sv
// Shared types and constants for the retire performance monitor.
// Counter-select codes double as the bit order of the per-counter increment vector.
package perf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HALTED  = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [3:0] SEL_CYCLES   = 4'd0;
   localparam logic [3:0] SEL_INSTRET  = 4'd1;
   localparam logic [3:0] SEL_LOADS    = 4'd2;
   localparam logic [3:0] SEL_STORES   = 4'd3;
   localparam logic [3:0] SEL_TRAPS    = 4'd4;
   localparam logic [3:0] SEL_BRANCHES = 4'd5;
   localparam logic [3:0] SEL_JUMPS    = 4'd6;
   localparam logic [3:0] SEL_STALLS   = 4'd7;
   localparam logic [3:0] SEL_STATE    = 4'd8;

   localparam int NUM_CNT = 8;

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter: holds at all-ones, synchronous clear beats increment.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (i_clear)
         count_d = '0;
      else if (i_inc && (count_q != '1))
         count_d = count_q + ONE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign o_count = count_q;

endmodule

// File: rtl/retire_perf_monitor.sv
// Run-state FSM plus eight saturating event counters fed by the hart retire port,
// with a registered one-cycle-latency read port.
//
//  state   | meaning
//  IDLE    | waiting for the first retire; nothing counted
//  RUN     | every clock counted, events accumulated
//  HALTED  | halt instruction retired; counters frozen
//  TIMEOUT | cycle budget exhausted; counters frozen
module retire_perf_monitor
   import perf_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 400000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_retire_valid,
   input  logic [31:0]      i_retire_inst,
   input  logic             i_retire_trap,
   input  logic             i_retire_halt,
   input  logic             i_retire_dmem_ren,
   input  logic             i_retire_dmem_wen,
   input  logic             i_clear,
   input  logic             i_rd_en,
   input  logic [3:0]       i_rd_sel,
   output logic             o_rd_valid,
   output logic [CNT_W-1:0] o_rd_data,
   output logic [1:0]       o_state,
   output logic             o_done,
   output logic             o_timeout
);

   localparam logic [63:0] LAST_CYCLE = 64'(MAX_CYCLES - 1);

   state_e             state_q, state_d;
   logic               done_q, timeout_q, rd_valid_q;
   logic [CNT_W-1:0]   rd_data_q, rd_mux;
   logic [CNT_W-1:0]   cnt [NUM_CNT];
   logic [CNT_W-1:0]   cycles;
   logic [NUM_CNT-1:0] inc;
   logic [6:0]         opcode;
   logic               run, counted, ev;
   logic               unused_inst_hi;

   assign opcode         = i_retire_inst[6:0];
   assign unused_inst_hi = ^i_retire_inst[31:7];
   assign cycles         = cnt[0];
   assign run            = (state_q == ST_RUN);
   assign counted        = run || ((state_q == ST_IDLE) && i_retire_valid);
   assign ev             = counted && i_retire_valid;

   // Bit order follows the SEL_* codes so the read mux can index cnt directly.
   assign inc = {run && !i_retire_valid,
                 ev && ((opcode == OP_JAL) || (opcode == OP_JALR)),
                 ev && (opcode == OP_BRANCH),
                 ev && i_retire_trap,
                 ev && i_retire_dmem_wen,
                 ev && i_retire_dmem_ren,
                 ev,
                 counted};

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      perf_counter #(.CNT_W(CNT_W)) u_cnt (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_clear (i_clear),
         .i_inc   (inc[g]),
         .o_count (cnt[g])
      );
   end

   // A halt on the budget's last cycle is reported as HALTED, not TIMEOUT.
   always_comb begin
      state_d = state_q;
      if (i_clear)
         state_d = ST_IDLE;
      else begin
         case (state_q)
            ST_IDLE:
               if (i_retire_valid)
                  state_d = i_retire_halt ? ST_HALTED : ST_RUN;
            ST_RUN:
               if (i_retire_valid && i_retire_halt)
                  state_d = ST_HALTED;
               else if (64'(cycles) == LAST_CYCLE)
                  state_d = ST_TIMEOUT;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      if (i_rd_sel <= SEL_STALLS)
         rd_mux = cnt[i_rd_sel[2:0]];
      else if (i_rd_sel == SEL_STATE)
         rd_mux = {{(CNT_W-2){1'b0}}, state_q};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         done_q     <= (state_d == ST_HALTED);
         timeout_q  <= (state_d == ST_TIMEOUT);
         rd_valid_q <= i_rd_en;
         if (i_rd_en)
            rd_data_q <= rd_mux;
      end
   end

   assign o_state    = state_q;
   assign o_done     = done_q;
   assign o_timeout  = timeout_q;
   assign o_rd_valid = rd_valid_q;
   assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_retire_perf_monitor.sv
// Bench for retire_perf_monitor: two instances (short timeout, 4-bit counters) share
// directed stimulus; an integer model is compared every cycle, plus literal read checks.
module tb_retire_perf_monitor;

   localparam int NI = 2;
   localparam logic [31:0] I_NOP = 32'h0000_0013;
   localparam logic [31:0] I_BR  = 32'h0000_0063;
   localparam logic [31:0] I_JAL = 32'h0000_006F;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        valid = 1'b0, trap = 1'b0, halt = 1'b0, ren = 1'b0, wen = 1'b0;
   logic        clear = 1'b0, rd_en = 1'b0;
   logic [31:0] inst = I_NOP;
   logic [3:0]  rd_sel = 4'd0;

   logic        rv_a, done_a, to_a, rv_b, done_b, to_b;
   logic [1:0]  st_a, st_b;
   logic [31:0] rd_a;
   logic [3:0]  rd_b;

   int tests = 0, failed = 0;

   always #5 clk = ~clk;

   retire_perf_monitor #(.CNT_W(32), .MAX_CYCLES(20)) u_main (
      .i_clk(clk), .i_rst_n(rst_n), .i_retire_valid(valid), .i_retire_inst(inst),
      .i_retire_trap(trap), .i_retire_halt(halt), .i_retire_dmem_ren(ren),
      .i_retire_dmem_wen(wen), .i_clear(clear), .i_rd_en(rd_en), .i_rd_sel(rd_sel),
      .o_rd_valid(rv_a), .o_rd_data(rd_a), .o_state(st_a), .o_done(done_a), .o_timeout(to_a));

   retire_perf_monitor #(.CNT_W(4), .MAX_CYCLES(400000)) u_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_retire_valid(valid), .i_retire_inst(inst),
      .i_retire_trap(trap), .i_retire_halt(halt), .i_retire_dmem_ren(ren),
      .i_retire_dmem_wen(wen), .i_clear(clear), .i_rd_en(rd_en), .i_rd_sel(rd_sel),
      .o_rd_valid(rv_b), .o_rd_data(rd_b), .o_state(st_b), .o_done(done_b), .o_timeout(to_b));

   // Model: state as 0..3, counters as wide integers capped at 2^CNT_W-1.
   longint unsigned cap  [NI] = '{64'hFFFF_FFFF, 64'd15};
   longint unsigned maxc [NI] = '{64'd20, 64'd400000};
   int              m_state [NI];
   longint unsigned m_cnt [NI][8];
   longint unsigned m_rd [NI];
   bit              m_rv;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void bump(input int k, input int idx);
      if (m_cnt[k][idx] < cap[k]) m_cnt[k][idx]++;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NI; k++) begin
         m_state[k] = 0;
         m_rd[k]    = 0;
         for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
      end
      m_rv = 1'b0;
   endfunction

   function automatic void model_step();
      bit act;
      for (int k = 0; k < NI; k++) begin
         act = (m_state[k] == 1) || (m_state[k] == 0 && valid);
         if (rd_en)
            m_rd[k] = (rd_sel < 8) ? m_cnt[k][rd_sel] :
                      (rd_sel == 8) ? longint'(m_state[k]) : 0;
         if (clear) begin
            m_state[k] = 0;
            for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
         end else if (act) begin
            bump(k, 0);
            if (valid) begin
               bump(k, 1);
               if (ren) bump(k, 2);
               if (wen) bump(k, 3);
               if (trap) bump(k, 4);
               if (inst[6:0] == 7'h63) bump(k, 5);
               if (inst[6:0] == 7'h6F || inst[6:0] == 7'h67) bump(k, 6);
            end else begin
               bump(k, 7);
            end
            if (valid && halt)              m_state[k] = 2;
            else if (m_cnt[k][0] == maxc[k]) m_state[k] = 3;
            else                            m_state[k] = 1;
         end
      end
      m_rv = rd_en;
   endfunction

   task automatic compare();
      chk("state_a",   st_a,   longint'(m_state[0]));
      chk("done_a",    done_a, longint'(m_state[0] == 2));
      chk("timeout_a", to_a,   longint'(m_state[0] == 3));
      chk("rdvalid_a", rv_a,   longint'(m_rv));
      chk("rddata_a",  rd_a,   m_rd[0]);
      chk("state_b",   st_b,   longint'(m_state[1]));
      chk("done_b",    done_b, longint'(m_state[1] == 2));
      chk("timeout_b", to_b,   longint'(m_state[1] == 3));
      chk("rdvalid_b", rv_b,   longint'(m_rv));
      chk("rddata_b",  rd_b,   m_rd[1]);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            model_step();
            #1;
            compare();
         end
      end
   end

   // Stimulus helpers; all called at a falling edge and return at a falling edge.
   task automatic retire(input logic [31:0] ins, input bit tr, input bit hl,
                         input bit ld, input bit st);
      valid = 1'b1; inst = ins; trap = tr; halt = hl; ren = ld; wen = st;
      @(negedge clk);
      valid = 1'b0; inst = I_NOP; trap = 1'b0; halt = 1'b0; ren = 1'b0; wen = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [3:0] s,
                         input longint unsigned ea, input longint unsigned eb);
      rd_en = 1'b1; rd_sel = s;
      @(negedge clk);
      rd_en = 1'b0;
      chk({nm, "_a"}, rd_a, ea);
      chk({nm, "_b"}, rd_b, eb);
   endtask

   initial begin
      #1;
      chk("rst_state", st_a, 0);
      chk("rst_rdvalid", rv_a, 0);
      chk("rst_rddata", rd_a, 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // Ten retires, the last halting; later retires must be ignored.
      for (int i = 0; i < 9; i++) retire(I_NOP, 0, 0, 0, 0);
      retire(I_NOP, 0, 1, 0, 0);
      chk("halt_state", st_a, 2);
      chk("halt_done", done_a, 1);
      for (int i = 0; i < 3; i++) retire(I_NOP, 0, 0, 0, 0);
      rd_chk("t1_cycles", 4'd0, 10, 10);
      rd_chk("t1_instret", 4'd1, 10, 10);
      rd_chk("t1_stalls", 4'd7, 0, 0);
      rd_chk("t1_state", 4'd8, 2, 2);
      do_clear();

      // jal, stall, stall, load, stall, store+halt+trap
      retire(I_JAL, 0, 0, 0, 0);
      idle(2);
      retire(I_NOP, 0, 0, 1, 0);
      idle(1);
      retire(I_NOP, 1, 1, 0, 1);
      rd_chk("t2_cycles", 4'd0, 6, 6);
      rd_chk("t2_instret", 4'd1, 3, 3);
      rd_chk("t2_loads", 4'd2, 1, 1);
      rd_chk("t2_stores", 4'd3, 1, 1);
      rd_chk("t2_traps", 4'd4, 1, 1);
      rd_chk("t2_branches", 4'd5, 0, 0);
      rd_chk("t2_jumps", 4'd6, 1, 1);
      rd_chk("t2_stalls", 4'd7, 3, 3);
      do_clear();

      // Clear coinciding with a branch retire and a read of the branch counter.
      retire(I_NOP, 0, 0, 0, 0);
      retire(I_BR, 0, 0, 0, 0);
      valid = 1'b1; inst = I_BR; clear = 1'b1; rd_en = 1'b1; rd_sel = 4'd5;
      @(negedge clk);
      valid = 1'b0; inst = I_NOP; clear = 1'b0; rd_en = 1'b0;
      chk("t3_preclear_rd", rd_a, 1);
      chk("t3_state", st_a, 0);
      rd_chk("t3_branches", 4'd5, 0, 0);
      rd_chk("t3_cycles", 4'd0, 0, 0);

      // Asynchronous reset in RUN after five retires.
      for (int i = 0; i < 5; i++) retire(I_NOP, 0, 0, 0, 0);
      rd_chk("t4_instret", 4'd1, 5, 5);
      rst_n = 1'b0;
      #1;
      chk("t4_state", st_a, 0);
      chk("t4_rdvalid", rv_a, 0);
      chk("t4_rddata_a", rd_a, 0);
      chk("t4_rddata_b", rd_b, 0);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk("t4_cycles", 4'd0, 0, 0);
      rd_chk("t4_instret0", 4'd1, 0, 0);

      // One retire then silence: short budget times out at 20, 4-bit copy saturates.
      retire(I_NOP, 0, 0, 0, 0);
      idle(25);
      chk("t5_state_a", st_a, 3);
      chk("t5_timeout_a", to_a, 1);
      chk("t5_state_b", st_b, 1);
      rd_chk("t5_cycles", 4'd0, 20, 15);
      idle(3);
      rd_chk("t5_cycles_hold", 4'd0, 20, 15);
      rd_chk("t5_stalls", 4'd7, 19, 15);
      rd_chk("t5_state", 4'd8, 3, 1);
      do_clear();

      // Twenty back-to-back retires without halt.
      for (int i = 0; i < 20; i++) retire(I_NOP, 0, 0, 0, 0);
      rd_chk("t6_instret", 4'd1, 20, 15);
      rd_chk("t6_sel9", 4'd9, 0, 0);
      rd_chk("t6_sel15", 4'd15, 0, 0);
      do_clear();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
      $fatal(1);
   end

endmodule
